pwm_peripheral: RTL and testbench
=================================

# pwm_peripheral

Output stage fed by `spi_peripheral`. Consumes its five configuration registers (output enables, PWM enables, duty cycle) and drives 16 output pins. Each pin is static low, static high, or a shared ~3 kHz PWM waveform. Duty-cycle updates are double-buffered and applied only at period boundaries, so no runt or glitched pulses appear.

## Interface

Parameters:
- `CLK_DIV`, default 13: system clocks per PWM step. PWM frequency is f_clk / (CLK_DIV·256), which gives ≈3.0 kHz at 10 MHz. Legal range is 1..255.

Ports:
- `clk`  in  1  system clock. One clock domain only. All logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en_reg_out_7_0`  in  8  output enable, pins 7..0.
- `en_reg_out_15_8`  in  8  output enable, pins 15..8.
- `en_reg_pwm_7_0`  in  8  PWM select, pins 7..0.
- `en_reg_pwm_15_8`  in  8  PWM select, pins 15..8.
- `pwm_duty_cycle`  in  8  requested duty. High steps per period = value; 0xFF means 100 %.
- `out`  out  16  registered pin drive. Bit i maps to enable bit i.
- `pwm_sync`  out  1  one-cycle strobe in the first cycle that `out` reflects a new period.

## Operation

- **Prescaler** `pre_cnt` (width $clog2(CLK_DIV), minimum 1):
  - Counts 0..CLK_DIV-1, then wraps.
  - `tick` = (pre_cnt == CLK_DIV-1).
  - With CLK_DIV=1, `tick` is asserted every cycle.
- **Step counter** `pwm_cnt` (8 bit):
  - Increments on `tick`.
  - Wraps 255→0 naturally. No terminal-count logic beyond the 8-bit overflow.
- **Duty shadow** `duty_sh`:
  - Loads `pwm_duty_cycle` on the cycle where `tick && pwm_cnt==255`. Otherwise it holds.
  - Input changes mid-period are ignored until the next boundary.
- **PWM level**: `level` = (duty_sh==8'hFF) || (pwm_cnt < duty_sh).
  - duty 0 gives always low.
  - duty 0xFF gives always high, with no 1-step dip.
  - duty N in 1..254 gives N·CLK_DIV high clocks per period.
- **Pin mux**, per bit i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - en_out[i]==0 → 0.
  - en_out[i]==1, en_pwm[i]==0 → 1.
  - en_out[i]==1, en_pwm[i]==1 → `level`.
- **Enable-only changes** (no PWM involvement) reach `out` on the next clock. There is no boundary wait for these.
- **Free-running counters**: `pre_cnt` and `pwm_cnt` run regardless of enables. All PWM pins are phase-aligned to one shared counter.
- **Reset values**, applied asynchronously including mid-period:
  - pre_cnt=0, pwm_cnt=0, duty_sh=0.
  - out=16'h0000, pwm_sync=0.
  - The first period after reset therefore outputs 0 on PWM pins, even if duty is already non-zero.

## Timing

- **Cycle numbering**: cycle R is the first clock after rst_n deasserts.
  - `tick` first occurs at R+CLK_DIV-1.
  - `pwm_cnt` becomes 1 at R+CLK_DIV.
- **Pipeline latency**: `out` is registered from combinational `level`/enables, so it lags `pwm_cnt` by exactly 1 clock.
- **Boundary timing**: the boundary tick occurs at cycle B.
  - At B+1: pwm_cnt=0 and the new duty_sh is in place.
  - At B+2: `out` shows the new period, and `pwm_sync`=1 for that one cycle. `pwm_sync` uses one extra delay flop so it aligns with `out`.
- **Period length**: exactly 256·CLK_DIV clocks. Successive `pwm_sync` pulses are 3328 clocks apart with the default CLK_DIV.
- **Simultaneous events**:
  - If `pwm_duty_cycle` changes in the boundary cycle B itself, the new value is captured.
  - If it changes at B+1, it waits a full period.
  - An enable change and a boundary in the same cycle are both honoured. They are independent.

## Structure

- **Shared package** `pwm_pkg`:
  - `PWM_STEPS` = 256.
  - `PWM_CLK_DIV_DEFAULT` = 13.
  - `DUTY_FULL` = 8'hFF.
  - `NUM_PINS` = 16.
- **Sub-module** `pwm_prescaler`:
  - Parameter CLK_DIV.
  - Ports clk, rst_n, tick.
  - Contains `pre_cnt` only.
- **Top level** contains `pwm_cnt`, `duty_sh`, the level compare, the pin mux, and the output/sync registers.

## Test plan

All scenarios use CLK_DIV=13 and a 10 MHz clock.

- **Static pins**: en_out=16'h00FF, en_pwm=0 → out=16'h00FF one clock after the enables settle, and it never toggles over 2 periods.
- **Half duty**: duty=0x80, en_out=en_pwm=16'h0001, wait one boundary → out[0] is high 1664 clocks and low 1664 clocks. Edges align with `pwm_sync`. Period is 3328 clocks.
- **Extremes**:
  - duty=0x00 → out[0] is constant 0 across 3 periods.
  - duty=0xFF → out[0] is constant 1 across 3 periods.
  - duty=0x01 → high for exactly 13 clocks per period.
- **Glitch-free update**: switch duty 0x40→0xC0 at mid-period → the current period keeps 832 high clocks. The next period, starting with `pwm_sync`, has 2496 high clocks. No pulse is shorter than 13 clocks.
- **Mixed mux**:
  - Inputs: en_out=16'hF0F0, en_pwm=16'h3030, duty=0x80.
  - Pins 4, 5, 12, 13 toggle in phase.
  - Pins 6, 7, 14, 15 stay high.
  - All other pins stay low.
- **Reset mid-operation**: assert rst_n low at an arbitrary point inside a high PWM phase → out=0 and pwm_sync=0 immediately, with no clock needed. After release, the first period is low and the first `pwm_sync` arrives at R+3328+1.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output stage.
// Pin mux lives here so any other consumer of the enables agrees on it.
package pwm_pkg;

  localparam int PWM_STEPS           = 256;
  localparam int PWM_CLK_DIV_DEFAULT = 13;
  localparam int NUM_PINS            = 16;
  localparam int CNT_W               = $clog2(PWM_STEPS);

  localparam logic [CNT_W-1:0] DUTY_FULL = 8'hFF;

  typedef logic [NUM_PINS-1:0] pin_vec_t;
  typedef logic [CNT_W-1:0]    step_t;

  function automatic pin_vec_t pin_mux(
    input pin_vec_t en_out,
    input pin_vec_t en_pwm,
    input logic     level
  );
    return en_out & (~en_pwm | {NUM_PINS{level}});
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides the system clock down to one PWM step strobe
// every CLK_DIV clocks.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] pre_cnt_q;
  logic [W-1:0] pre_cnt_d;

  always_comb begin
    tick      = (pre_cnt_q == LAST);
    pre_cnt_d = tick ? '0 : pre_cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output stage: static low/high or shared PWM per pin,
// with duty double-buffered to period boundaries.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          en_reg_out_7_0,
  input  logic [7:0]          en_reg_out_15_8,
  input  logic [7:0]          en_reg_pwm_7_0,
  input  logic [7:0]          en_reg_pwm_15_8,
  input  logic [7:0]          pwm_duty_cycle,
  output logic [NUM_PINS-1:0] out,
  output logic                pwm_sync
);

  logic     tick;
  logic     boundary;
  logic     level;
  step_t    pwm_cnt_q, pwm_cnt_d;
  step_t    duty_sh_q, duty_sh_d;
  pin_vec_t out_q, out_d;
  pin_vec_t en_out, en_pwm;
  logic     bnd_q;
  logic     sync_q;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    boundary  = tick && (pwm_cnt_q == '1);
    pwm_cnt_d = tick ? pwm_cnt_q + step_t'(1) : pwm_cnt_q;
    duty_sh_d = boundary ? pwm_duty_cycle : duty_sh_q;
    level     = (duty_sh_q == DUTY_FULL) || (pwm_cnt_q < duty_sh_q);
    out_d     = pin_mux(en_out, en_pwm, level);
  end

  // bnd_q -> sync_q delays the strobe two clocks so it lines up with out_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      duty_sh_q <= '0;
      out_q     <= '0;
      bnd_q     <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_sh_q <= duty_sh_d;
      out_q     <= out_d;
      bnd_q     <= boundary;
      sync_q    <= bnd_q;
    end
  end

  assign out      = out_q;
  assign pwm_sync = sync_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral at CLK_DIV=13, 10 MHz clock.
// Period 3328 clocks; half duty 1664; one step 13.
module tb_pwm_peripheral;

  localparam int PER = 3328;

  logic        clk;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        pwm_sync;

  int tests;
  int fails;

  pwm_peripheral #(
    .CLK_DIV (13)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .pwm_sync        (pwm_sync)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_sync();
    int n;
    n = 0;
    while (pwm_sync !== 1'b1 && n < 2 * PER) begin
      @(negedge clk);
      n++;
    end
    check("wait_sync", {31'd0, pwm_sync}, 32'd1);
  endtask

  // Called on the negedge where pwm_sync is high; returns on the next one.
  task automatic run_period(input int b, input int chg, input logic [7:0] nd,
                            output int hi, output int minp);
    int run;
    int extra;
    hi = 0; run = 0; extra = 0; minp = 99999;
    for (int i = 0; i < PER; i++) begin
      if (out[b]) begin
        hi++;
        run++;
      end else if (run > 0) begin
        if (run < minp) minp = run;
        run = 0;
      end
      if (i > 0 && pwm_sync) extra++;
      if (i == chg) duty = nd;
      @(negedge clk);
    end
    if (run > 0 && run < minp) minp = run;
    check("no_extra_sync", extra, 0);
    check("period_sync", {31'd0, pwm_sync}, 32'd1);
  endtask

  task automatic first_sync_after_release(output int n, output int hi);
    n = 0; hi = 0;
    while (pwm_sync !== 1'b1 && n < 2 * PER) begin
      @(negedge clk);
      n++;
      if (!pwm_sync && out[0]) hi++;
    end
  endtask

  initial begin
    int hi, minp, n, tot, bad, hi4, tog;
    logic [15:0] ref_out;
    tests = 0;
    fails = 0;
    rst_n  = 1'b1;
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h80;
    #5 rst_n = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_sync", {31'd0, pwm_sync}, 32'd0);

    // first period after release is low; first sync at R+3329
    rst_n = 1'b1;
    first_sync_after_release(n, hi);
    check("first_sync_cycle", n, 3329);
    check("first_period_low", hi, 0);

    // half duty, starts high at sync
    check("half_first_high", {31'd0, out[0]}, 32'd1);
    run_period(0, -1, 8'h80, hi, minp);
    check("half_hi", hi, 1664);

    // static pins
    en_out = 16'h00FF;
    en_pwm = 16'h0000;
    @(negedge clk);
    check("static_out", {16'd0, out}, 32'h00FF);
    tog = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge clk);
      if (out !== 16'h00FF) tog++;
    end
    check("static_stable", tog, 0);

    // duty 0x00
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h00;
    wait_sync();
    tot = 0;
    for (int p = 0; p < 3; p++) begin
      run_period(0, -1, 8'h00, hi, minp);
      tot += hi;
    end
    check("duty00_hi", tot, 0);

    // duty 0xFF
    duty = 8'hFF;
    run_period(0, -1, 8'hFF, hi, minp);
    tot = 0;
    for (int p = 0; p < 3; p++) begin
      run_period(0, -1, 8'hFF, hi, minp);
      tot += hi;
    end
    check("dutyFF_hi", tot, 3 * PER);

    // duty 0x01
    duty = 8'h01;
    run_period(0, -1, 8'h01, hi, minp);
    check("duty01_first", {31'd0, out[0]}, 32'd1);
    run_period(0, -1, 8'h01, hi, minp);
    check("duty01_hi", hi, 13);

    // glitch-free update mid-period
    duty = 8'h40;
    run_period(0, -1, 8'h40, hi, minp);
    run_period(0, PER / 2, 8'hC0, hi, minp);
    check("upd_cur_hi", hi, 832);
    check("upd_cur_minp", {31'd0, minp >= 13}, 32'd1);
    run_period(0, -1, 8'hC0, hi, minp);
    check("upd_next_hi", hi, 2496);
    check("upd_next_minp", {31'd0, minp >= 13}, 32'd1);

    // mixed mux
    en_out = 16'hF0F0;
    en_pwm = 16'h3030;
    duty   = 8'h80;
    run_period(4, -1, 8'h80, hi, minp);
    bad = 0;
    hi4 = 0;
    for (int i = 0; i < PER; i++) begin
      if (out[4]) begin
        hi4++;
        ref_out = 16'hF0F0;
      end else begin
        ref_out = 16'hC0C0;
      end
      if (out !== ref_out) bad++;
      @(negedge clk);
    end
    check("mix_bad", bad, 0);
    check("mix_hi4", hi4, 1664);
    check("mix_sync", {31'd0, pwm_sync}, 32'd1);

    // async reset inside a high phase
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    repeat (3) @(negedge clk);
    check("pre_rst_high", {31'd0, out[0]}, 32'd1);
    #20 rst_n = 1'b0;
    #1;
    check("async_rst_out", {16'd0, out}, 32'd0);
    check("async_rst_sync", {31'd0, pwm_sync}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    first_sync_after_release(n, hi);
    check("re_first_sync", n, 3329);
    check("re_first_low", hi, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
